// File: rtl/led_ring_decoder.sv
// led_ring_decoder: receive side of the hour-ring / quarter display bus.
// Synchronises and debounces the 16 lines, checks them for one-hot form,
// decodes binary hour/quarter and flags malformed words and illegal steps.
module led_ring_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          ring_in,
  input  logic [3:0]           quad_in,
  input  logic                 clr_err,
  output logic [3:0]           hour,
  output logic [1:0]           quarter,
  output logic                 valid,
  output logic                 update,
  output logic                 fmt_err,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] ACCEPT_PRE = 4'(STABLE_CYCLES - 2);

  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_hist;
  logic [3:0]  r_stab_cnt;
  logic        r_accepted;

  logic        w_same;
  logic        w_accept;
  logic [11:0] w_ring;
  logic [3:0]  w_quad;
  logic [3:0]  w_h;
  logic [1:0]  w_q;
  logic        w_idle;
  logic        w_good;
  logic        w_fmt;
  logic        w_same_val;
  logic        w_legal;
  logic [3:0]  w_next_h;
  logic        w_seq;
  logic        w_err_evt;

  assign w_ring   = r_sync2[11:0];
  assign w_quad   = r_sync2[15:12];
  assign w_same   = (r_sync2 == r_hist);
  // The word is taken exactly once: on the edge its run count reaches STABLE_CYCLES-1.
  assign w_accept = w_same && !r_accepted && (r_stab_cnt == ACCEPT_PRE);

  assign w_idle     = (w_ring == 12'd0) && (w_quad == 4'd0);
  assign w_good     = $onehot(w_ring) && $onehot(w_quad);
  assign w_fmt      = !w_idle && !w_good;
  assign w_same_val = (w_h == hour) && (w_q == quarter);
  assign w_next_h   = (hour == 4'd11) ? 4'd0 : hour + 4'd1;
  assign w_seq      = w_good && valid && !w_legal;
  assign w_err_evt  = w_accept && (w_fmt || w_seq);

  // Convert the one-hot fields to bit indices; only meaningful for good words.
  always_comb begin
    w_h = 4'd0;
    w_q = 2'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_ring[i]) w_h = 4'(i);
    end
    for (int j = 0; j < 4; j++) begin
      if (w_quad[j]) w_q = 2'(j);
    end
  end

  // Legal next displays: same time, next quarter, or hour rollover after quarter 3.
  always_comb begin
    w_legal = w_same_val;
    if (quarter != 2'd3) begin
      if ((w_h == hour) && (w_q == quarter + 2'd1)) w_legal = 1'b1;
    end else begin
      if ((w_h == w_next_h) && (w_q == 2'd0)) w_legal = 1'b1;
    end
  end

  // Two-flop synchroniser plus history of the previous synchronised word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 16'd0;
      r_sync2 <= 16'd0;
      r_hist  <= 16'd0;
    end else begin
      r_sync1 <= {quad_in, ring_in};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Stability run counter; any change restarts the run and re-arms acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab_cnt <= 4'd0;
      r_accepted <= 1'b0;
    end else if (!w_same) begin
      r_stab_cnt <= 4'd0;
      r_accepted <= 1'b0;
    end else begin
      if (r_stab_cnt != STABLE_MAX) r_stab_cnt <= r_stab_cnt + 4'd1;
      if (w_accept) r_accepted <= 1'b1;
    end
  end

  // Classify accepted words and drive the published time and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour    <= 4'd0;
      quarter <= 2'd0;
      valid   <= 1'b0;
      update  <= 1'b0;
      fmt_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      update  <= 1'b0;
      fmt_err <= 1'b0;
      seq_err <= 1'b0;
      if (w_accept) begin
        if (w_idle) begin
          valid <= 1'b0;
        end else if (w_fmt) begin
          fmt_err <= 1'b1;
        end else begin
          hour    <= w_h;
          quarter <= w_q;
          valid   <= 1'b1;
          update  <= !valid || !w_same_val;
          seq_err <= w_seq;
        end
      end
    end
  end

  // Saturating error counter; a clear request beats a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (w_err_evt && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_ring_decoder.sv
// tb_led_ring_decoder: directed vectors with an expected-event queue drained
// by an independent monitor whenever the decoder pulses update/fmt_err/seq_err.
module tb_led_ring_decoder;

  logic        clk;
  logic        rst_n;
  logic [11:0] ring_in;
  logic [3:0]  quad_in;
  logic        clr_err;
  logic [3:0]  hour;
  logic [1:0]  quarter;
  logic        valid;
  logic        update;
  logic        fmt_err;
  logic        seq_err;
  logic [3:0]  err_count;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic [3:0] h;
    logic [1:0] q;
    logic       v;
    logic       upd;
    logic       fe;
    logic       se;
    logic [3:0] ec;
  } ev_t;

  ev_t expQ[$];

  led_ring_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ring_in   (ring_in),
    .quad_in   (quad_in),
    .clr_err   (clr_err),
    .hour      (hour),
    .quarter   (quarter),
    .valid     (valid),
    .update    (update),
    .fmt_err   (fmt_err),
    .seq_err   (seq_err),
    .err_count (err_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Event monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (update || fmt_err || seq_err) begin
      ev_t got;
      got = '{h: hour, q: quarter, v: valid, upd: update, fe: fmt_err, se: seq_err, ec: err_count};
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_event got h=%0d q=%0d v=%0b upd=%0b fe=%0b se=%0b ec=%0d required no event",
                 got.h, got.q, got.v, got.upd, got.fe, got.se, got.ec);
      end else begin
        ev_t exp_ev;
        exp_ev = expQ.pop_front();
        if (got !== exp_ev) begin
          nMismatched++;
          $display("[TB] FAIL event got h=%0d q=%0d v=%0b upd=%0b fe=%0b se=%0b ec=%0d required h=%0d q=%0d v=%0b upd=%0b fe=%0b se=%0b ec=%0d",
                   got.h, got.q, got.v, got.upd, got.fe, got.se, got.ec,
                   exp_ev.h, exp_ev.q, exp_ev.v, exp_ev.upd, exp_ev.fe, exp_ev.se, exp_ev.ec);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int h, input int q, input bit v, input bit u,
                         input bit fe, input bit se, input int ec);
    ev_t e;
    e = '{h: 4'(h), q: 2'(q), v: v, upd: u, fe: fe, se: se, ec: 4'(ec)};
    expQ.push_back(e);
  endtask

  // Drive a word at a falling edge and hold it for the given number of cycles.
  task automatic applyStimulus(input logic [11:0] r, input logic [3:0] q, input int cycles);
    ring_in = r;
    quad_in = q;
    repeat (cycles) @(negedge clk);
  endtask

  // After a reset release, nothing may publish before edge 6; edge 6 publishes (h,q).
  task automatic checkLatency(input string name, input int h, input int q);
    repeat (5) @(posedge clk);
    #1;
    checkOutput({name, "_early_update"}, 32'(update), 32'd0);
    checkOutput({name, "_early_valid"}, 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, "_edge6_update"}, 32'(update), 32'd1);
    checkOutput({name, "_edge6_time"}, 32'({hour, quarter, valid}), 32'({4'(h), 2'(q), 1'b1}));
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, 32'({hour, quarter, valid, update, fmt_err, seq_err, err_count}), 32'd0);
  endtask

  initial begin
    $display("[TB] starting led_ring_decoder bench");
    rst_n   = 1'b0;
    clr_err = 1'b0;
    ring_in = 12'h020;
    quad_in = 4'h4;
    repeat (3) @(negedge clk);
    checkAllZero("reset_state");

    // First good word after reset: no successor check, publishes on edge 6.
    pushExp(5, 2, 1, 1, 0, 0, 0);
    rst_n = 1'b1;
    checkLatency("first_word", 5, 2);
    repeat (6) @(negedge clk);

    // Legal progression (5,3) -> (6,0) -> (6,1).
    pushExp(5, 3, 1, 1, 0, 0, 0);
    applyStimulus(12'h020, 4'h8, 10);
    pushExp(6, 0, 1, 1, 0, 0, 0);
    applyStimulus(12'h040, 4'h1, 10);
    pushExp(6, 1, 1, 1, 0, 0, 0);
    applyStimulus(12'h040, 4'h2, 10);
    checkOutput("legal_err_count", 32'(err_count), 32'd0);

    // Two malformed words: two ring bits, then empty ring with a quarter bit.
    pushExp(6, 1, 1, 0, 1, 0, 1);
    applyStimulus(12'h030, 4'h2, 10);
    pushExp(6, 1, 1, 0, 1, 0, 2);
    applyStimulus(12'h000, 4'h1, 10);
    checkOutput("fmt_hold_time", 32'({hour, quarter, valid}), 32'({4'd6, 2'd1, 1'b1}));

    // Skip (6,1) -> (9,0): published, with seq_err.
    pushExp(9, 0, 1, 1, 0, 1, 3);
    applyStimulus(12'h200, 4'h1, 10);

    // Idle drops valid silently; then (2,0) publishes without successor check.
    applyStimulus(12'h000, 4'h0, 10);
    checkOutput("idle_valid", 32'({valid, err_count}), 32'({1'b0, 4'd3}));
    pushExp(2, 0, 1, 1, 0, 0, 3);
    applyStimulus(12'h004, 4'h1, 10);

    // Three-cycle glitch to (7,3) is filtered out.
    applyStimulus(12'h080, 4'h8, 3);
    applyStimulus(12'h004, 4'h1, 12);
    checkOutput("glitch_hold", 32'({hour, quarter, valid, err_count}), 32'({4'd2, 2'd0, 1'b1, 4'd3}));

    // Idle again: valid falls, time and count held.
    applyStimulus(12'h000, 4'h0, 10);
    checkOutput("idle2_state", 32'({hour, quarter, valid, err_count}), 32'({4'd2, 2'd0, 1'b0, 4'd3}));

    // Twenty format errors drive the counter into saturation.
    for (int i = 1; i <= 20; i++) begin
      pushExp(2, 0, 0, 0, 1, 0, (3 + i > 15) ? 15 : 3 + i);
      applyStimulus((i % 2 == 1) ? 12'h030 : 12'h003, 4'h1, 7);
    end
    checkOutput("sat_err_count", 32'(err_count), 32'd15);

    // Clear requested on the very edge a new format error is accepted.
    pushExp(2, 0, 0, 0, 1, 0, 0);
    applyStimulus(12'h0C0, 4'h1, 0);
    repeat (5) @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    checkOutput("clr_err_count", 32'(err_count), 32'd0);
    repeat (4) @(negedge clk);

    // Reset in the middle of debouncing (3,0), then full re-debounce after release.
    applyStimulus(12'h008, 4'h1, 3);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset_state");
    repeat (2) @(negedge clk);
    pushExp(3, 0, 1, 1, 0, 0, 0);
    rst_n = 1'b1;
    checkLatency("after_reset", 3, 0);
    repeat (8) @(negedge clk);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/led_ring_decoder.md
Name: led_ring_decoder

Overview:
- Receiving end of the 12-LED hour ring / 4-LED quarter display bus driven by the ring-clock tile: 12 one-hot hour lines plus 4 one-hot quarter lines.
- Synchronises and debounces the 16 lines, validates them as one-hot, and converts them back to binary hour and quarter.
- Flags malformed words and illegal time steps, so a second tile can read, check and log another tile's display output.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a word is accepted (2..15)
- ERR_CNT_W, 4, width of the saturating error counter

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ring_in  input  12  hour ring lines, bit i = hour i, expected one-hot
- quad_in  input  4  quarter lines, bit j = quarter j, expected one-hot
- hour  output  4  binary hour 0..11 of the last accepted valid word
- quarter  output  2  binary quarter 0..3 of the last accepted valid word
- valid  output  1  hour/quarter hold a valid decoded time
- update  output  1  one-cycle pulse when hour/quarter change
- fmt_err  output  1  one-cycle pulse: accepted word not one-hot
- seq_err  output  1  one-cycle pulse: valid word is not a legal successor
- err_count  output  ERR_CNT_W  saturating count of fmt_err and seq_err events
- clr_err  input  1  synchronous clear of err_count; has priority over an increment in the same cycle

Behaviour:
- Reset (async, rst_n low): all outputs 0. Sync flops, stability counter, history register and the published flag are all cleared.
- Synchroniser: 2-flop synchroniser on all 16 input bits.
- Stability tracking: a 16-bit history register holds the previous synchronised word.
  - Word differs from history: stability counter = 0 and the accepted flag clears.
  - Word equals history: counter increments, saturating at STABLE_CYCLES.
- Acceptance: the word is accepted once, on the edge where the counter reaches STABLE_CYCLES-1. It is not re-accepted while it stays stable.
- Latency: an input change held steady produces its output effect on the edge 2+STABLE_CYCLES after the first edge that samples it. Default = 6 edges.
- Classification of an accepted word:
  - Idle (ring and quad both all-zero, source in reset): valid <= 0. hour/quarter hold their values. No error.
  - Format error (either field not exactly one bit set, including one field zero and the other non-zero): fmt_err pulses, err_count increments, outputs hold, valid unchanged.
  - Good (both fields one-hot): hour/quarter take the bit indices and valid <= 1.
    - update pulses if valid was 0 or the value differs from the held value.
- Successor check (good word while valid was already 1). Legal successors of (h,q):
  - (h,q+1) for q<3
  - ((h+1) mod 12, 0) for q=3
  - (h,q) itself, so no event
  - Any other good word: still published, update pulses, seq_err pulses the same cycle, err_count increments.
  - A good word arriving while valid=0 is never checked.
- err_count:
  - Increments by 1 per error event, saturating at all-ones.
  - fmt_err and seq_err are mutually exclusive per accept, so the counter never increments by 2.
  - clr_err clears the count the next edge; clear wins over a same-cycle increment.
- Glitches: an input pulse shorter than STABLE_CYCLES synchronised cycles never causes acceptance. The history simply restarts.
- Reset mid-operation: immediate return to the reset state. After release, the first good word publishes without a successor check.

Test Plan:
- Reset with rst_n low while inputs = (hour 5, quarter 2): all outputs 0. Release and hold ring=0x020, quad=0x4 → on edge 6: hour=5, quarter=2, valid=1, update=1 for one cycle; seq_err=0.
- Legal sequence (5,3) → (6,0) → (6,1), each word held 10 cycles → three update pulses, hour/quarter track exactly, seq_err never asserts, err_count=0.
- Format errors: while valid, hold ring=0x030 (two bits), then ring=0x000 with quad=0x1 → two fmt_err pulses, err_count=2, hour/quarter/valid unchanged.
- Skip: from (6,1) jump to (9,0) → hour=9, quarter=0, update and seq_err pulse in the same cycle, err_count increments by 1.
- Glitch filter: from (2,0), a 3-cycle pulse to (7,3) with STABLE_CYCLES=4 → no update, no error, outputs stay (2,0). Idle word (both zero) held 10 cycles → valid drops to 0, no error.
- Saturation/clear: inject 20 format errors → err_count=15 and stays. Assert clr_err in the same cycle as an error accept → err_count=0 next cycle. Reset asserted mid-debounce → no spurious update after release until a word has been stable for 6 edges.
